moka_run_sequencer: RTL and testbench

//  Synthesizable run controller for the moka_top RV32 core.

---
 rtl/moka_run_sequencer.sv | 130 +++++++++++++
 tb/tb_moka_run_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/moka_run_sequencer.sv
// Run controller for the moka_top core: sequences reset/enable after a start request,
// counts enabled run cycles and watches the data-memory write bus for a tohost store.
module moka_run_sequencer #(
   parameter int unsigned           RST_CYCLES     = 4,
   parameter int unsigned           EN_DELAY       = 2,
   parameter int unsigned           TIMEOUT_CYCLES = 1000,
   parameter int unsigned           CNT_WIDTH      = 32,
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 'h0000_1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  dut_rstn,
   output logic                  dut_en,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  fail,
   output logic                  timeout,
   output logic [DATA_WIDTH-1:0] exit_code,
   output logic [CNT_WIDTH-1:0]  cycle_count,
   output logic [2:0]            run_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RESET   = 3'd1,
      S_ARM     = 3'd2,
      S_RUN     = 3'd3,
      S_PASS    = 3'd4,
      S_FAIL    = 3'd5,
      S_TIMEOUT = 3'd6
   } state_t;

   localparam int unsigned PH_MAX = (RST_CYCLES > EN_DELAY) ? RST_CYCLES :
                                    ((EN_DELAY > 1) ? EN_DELAY : 1);
   localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;
   localparam logic [PH_W-1:0]      RST_LAST = PH_W'(RST_CYCLES - 1);
   localparam logic [PH_W-1:0]      ARM_LAST = (EN_DELAY == 0) ? '0 : PH_W'(EN_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic [PH_W-1:0]       phase_q, phase_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] exit_q, exit_d;
   logic                  en_run;
   logic                  hit;

   assign en_run = (state_q == S_RUN) && !pause;
   assign hit    = en_run && mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != '0);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      exit_d  = exit_q;
      case (state_q)
         S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
            // Every (re)run starts from a clean slate.
            if (start) begin
               state_d = S_RESET;
               phase_d = '0;
               cnt_d   = '0;
               exit_d  = '0;
            end
         end
         S_RESET: begin
            if (phase_q == RST_LAST) begin
               phase_d = '0;
               state_d = (EN_DELAY == 0) ? S_RUN : S_ARM;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         S_ARM: begin
            if (phase_q == ARM_LAST) begin
               phase_d = '0;
               state_d = S_RUN;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         S_RUN: begin
            // A tohost hit outranks a timeout landing on the same cycle.
            if (en_run) begin
               cnt_d = cnt_q + 1'b1;
               if (hit) begin
                  exit_d  = mem_wdata;
                  state_d = (mem_wdata == DATA_WIDTH'(1)) ? S_PASS : S_FAIL;
               end else if (cnt_q == TO_LAST) begin
                  state_d = S_TIMEOUT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         cnt_q   <= '0;
         exit_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         exit_q  <= exit_d;
      end
   end

   assign dut_rstn    = (state_q != S_IDLE) && (state_q != S_RESET);
   assign dut_en      = en_run;
   assign busy        = (state_q == S_RESET) || (state_q == S_ARM) || (state_q == S_RUN);
   assign done        = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
   assign pass        = (state_q == S_PASS);
   assign fail        = (state_q == S_FAIL);
   assign timeout     = (state_q == S_TIMEOUT);
   assign exit_code   = exit_q;
   assign cycle_count = cnt_q;
   assign run_state   = state_q;

endmodule

// File: tb/tb_moka_run_sequencer.sv
// Bench for moka_run_sequencer: randomized runs checked against a timeline model of
// reset/arm lengths, pause stretching, tohost outcome and timeout.
module tb_moka_run_sequencer;

   localparam int          TIMEOUT = 1000;
   localparam logic [31:0] TOHOST  = 32'h0000_1000;
   localparam int          T0      = 20;

   logic        clk = 1'b0;
   logic        rst, start, pause, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        dut_rstn, dut_en, busy, done, pass, fail, timeout;
   logic [31:0] exit_code, cycle_count;
   logic [2:0]  run_state;

   logic        start0, pause0, mem_we0;
   logic [31:0] mem_addr0, mem_wdata0;
   logic        dut_rstn0, dut_en0, busy0, done0, pass0, fail0, timeout0;
   logic [31:0] exit_code0, cycle_count0;
   logic [2:0]  run_state0;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   moka_run_sequencer u_dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dut_rstn(dut_rstn), .dut_en(dut_en),
      .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .exit_code(exit_code), .cycle_count(cycle_count), .run_state(run_state)
   );

   moka_run_sequencer #(.RST_CYCLES(3), .EN_DELAY(0), .TIMEOUT_CYCLES(T0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .pause(pause0), .mem_we(mem_we0),
      .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .dut_rstn(dut_rstn0), .dut_en(dut_en0),
      .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .timeout(timeout0),
      .exit_code(exit_code0), .cycle_count(cycle_count0), .run_state(run_state0)
   );

   // ---------------- driver tasks ----------------
   task automatic drive_startup(input bit hold, output int rst_lo, output int arm_cyc);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = hold;
      rst_lo = 0; arm_cyc = 0;
      for (int i = 0; i < 50 && run_state != 3'd3; i++) begin
         if (!dut_rstn) rst_lo++;
         else if (!dut_en) arm_cyc++;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   // Runs from a RUN-state negedge until the run ends; pause covers wall cycles
   // [pause_at, pause_at+pause_len); the tohost write lands on enabled cycle hit_at.
   task automatic drive_body(input int hit_at, input logic [31:0] hit_val, input int pause_at,
                             input int pause_len, output int wall, output int en_seen);
      int en_idx;
      bit p;
      wall = 0; en_seen = 0; en_idx = 0;
      while (run_state == 3'd3 && wall < 3000) begin
         p = (wall >= pause_at) && (wall < pause_at + pause_len);
         pause = p; mem_we = 1'b0; mem_addr = $urandom; mem_wdata = $urandom;
         if (!p && en_idx == hit_at) begin
            mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = hit_val;
         end else if ($urandom_range(0, 3) == 0) begin
            mem_we = 1'b1;
            if (p) begin
               mem_addr = TOHOST; mem_wdata = $urandom_range(1, 255);
            end else if ($urandom_range(0, 1) == 0) begin
               mem_addr = TOHOST; mem_wdata = 32'h0;
            end else begin
               mem_addr = TOHOST ^ (32'h1 << $urandom_range(2, 15));
               mem_wdata = $urandom_range(1, 255);
            end
         end
         #1;
         if (dut_en) en_seen++;
         if (!p) en_idx++;
         wall++;
         @(negedge clk);
      end
      pause = 1'b0; mem_we = 1'b0;
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; pause = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      start0 = 1'b0; pause0 = 1'b0; mem_we0 = 1'b0; mem_addr0 = '0; mem_wdata0 = '0;
      repeat (3) @(negedge clk);
      checks++; if (run_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", run_state); end
      checks++; if ({dut_rstn, dut_en} !== 2'b00) begin errors++; $display("FAIL reset_rstn_en: got %b want 00", {dut_rstn, dut_en}); end
      checks++; if ({busy, done, pass, fail, timeout} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {busy, done, pass, fail, timeout}); end
      checks++; if ({exit_code, cycle_count} !== 64'h0) begin errors++; $display("FAIL reset_regs: got %h/%h want 0/0", exit_code, cycle_count); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (run_state !== 3'd0 || dut_rstn !== 1'b0) begin errors++; $display("FAIL idle_hold: got state %0d rstn %b want 0 0", run_state, dut_rstn); end
   endtask

   task automatic test_startup();
      int lo, arm;
      drive_startup(1'b0, lo, arm);
      checks++; if (lo !== 4) begin errors++; $display("FAIL startup_rst_cycles: got %0d want 4", lo); end
      checks++; if (arm !== 2) begin errors++; $display("FAIL startup_arm_cycles: got %0d want 2", arm); end
      checks++; if ({run_state, dut_rstn, dut_en, busy, done} !== {3'd3, 4'b1110}) begin
         errors++; $display("FAIL startup_run: got %0d %b want 3 1110", run_state, {dut_rstn, dut_en, busy, done});
      end
   endtask

   task automatic test_pass();
      int wall, en;
      drive_body(37, 32'h1, -1, 0, wall, en);
      checks++; if ({pass, fail, timeout, done, busy, dut_en} !== 6'b100100) begin
         errors++; $display("FAIL pass_flags: got %b want 100100", {pass, fail, timeout, done, busy, dut_en});
      end
      checks++; if (exit_code !== 32'h1) begin errors++; $display("FAIL pass_exit: got %h want 1", exit_code); end
      checks++; if (cycle_count !== 32'd38) begin errors++; $display("FAIL pass_count: got %0d want 38", cycle_count); end
      checks++; if (wall !== 38 || en !== 38) begin errors++; $display("FAIL pass_wall: got %0d/%0d want 38/38", wall, en); end
      repeat (5) begin
         mem_we = 1'b1; mem_addr = TOHOST; mem_wdata = 32'h5;
         @(negedge clk);
      end
      mem_we = 1'b0;
      checks++; if ({run_state, cycle_count, exit_code, dut_en, dut_rstn} !== {3'd4, 32'd38, 32'h1, 2'b01}) begin
         errors++; $display("FAIL pass_hold: got %0d %0d %h %b want 4 38 1 01", run_state, cycle_count, exit_code, {dut_en, dut_rstn});
      end
   endtask

   task automatic test_fail_ignored();
      int lo, arm, wall, en, h, pa;
      drive_startup(1'b0, lo, arm);
      checks++; if (lo !== 4 || arm !== 2) begin errors++; $display("FAIL fail_startup: got %0d/%0d want 4/2", lo, arm); end
      h = $urandom_range(5, 200);
      pa = $urandom_range(0, h);
      drive_body(h, 32'h2A, pa, 3, wall, en);
      checks++; if ({pass, fail, timeout, done} !== 4'b0101) begin errors++; $display("FAIL fail_flags: got %b want 0101", {pass, fail, timeout, done}); end
      checks++; if (exit_code !== 32'h2A) begin errors++; $display("FAIL fail_exit: got %h want 2a", exit_code); end
      checks++; if (cycle_count !== 32'(h + 1)) begin errors++; $display("FAIL fail_count: got %0d want %0d", cycle_count, h + 1); end
      checks++; if (wall !== h + 4 || en !== h + 1) begin errors++; $display("FAIL fail_wall: got %0d/%0d want %0d/%0d", wall, en, h + 4, h + 1); end
   endtask

   task automatic test_timeout_pause();
      int lo, arm, wall, en;
      drive_startup(1'b0, lo, arm);
      drive_body(-1, 32'h0, 100, 10, wall, en);
      checks++; if ({pass, fail, timeout, done, run_state} !== {4'b0011, 3'd6}) begin
         errors++; $display("FAIL timeout_flags: got %b %0d want 0011 6", {pass, fail, timeout, done}, run_state);
      end
      checks++; if (cycle_count !== 32'(TIMEOUT)) begin errors++; $display("FAIL timeout_count: got %0d want %0d", cycle_count, TIMEOUT); end
      checks++; if (exit_code !== 32'h0) begin errors++; $display("FAIL timeout_exit: got %h want 0", exit_code); end
      checks++; if (wall !== TIMEOUT + 10 || en !== TIMEOUT) begin
         errors++; $display("FAIL timeout_wall: got %0d/%0d want %0d/%0d", wall, en, TIMEOUT + 10, TIMEOUT);
      end
   endtask

   task automatic test_hit_vs_timeout();
      int lo, arm, wall, en;
      drive_startup(1'b0, lo, arm);
      drive_body(TIMEOUT - 1, 32'h1, -1, 0, wall, en);
      checks++; if ({pass, fail, timeout} !== 3'b100) begin errors++; $display("FAIL race_flags: got %b want 100", {pass, fail, timeout}); end
      checks++; if (cycle_count !== 32'(TIMEOUT)) begin errors++; $display("FAIL race_count: got %0d want %0d", cycle_count, TIMEOUT); end
   endtask

   task automatic test_rerun();
      int lo, arm, wall, en;
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      checks++; if ({pass, fail, timeout, done, busy, dut_rstn} !== 6'b000010) begin
         errors++; $display("FAIL rerun_flags: got %b want 000010", {pass, fail, timeout, done, busy, dut_rstn});
      end
      checks++; if ({run_state, cycle_count, exit_code} !== {3'd1, 64'h0}) begin
         errors++; $display("FAIL rerun_regs: got %0d %0d %h want 1 0 0", run_state, cycle_count, exit_code);
      end
      // start stays high through RESET/ARM and must not restart the sequence
      lo = 0; arm = 0;
      for (int i = 0; i < 50 && run_state != 3'd3; i++) begin
         if (!dut_rstn) lo++;
         else if (!dut_en) arm++;
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (lo !== 4 || arm !== 2) begin errors++; $display("FAIL rerun_seq: got %0d/%0d want 4/2", lo, arm); end
      drive_body(3, 32'h7, -1, 0, wall, en);
      checks++; if ({fail, exit_code, cycle_count} !== {1'b1, 32'h7, 32'd4}) begin
         errors++; $display("FAIL rerun_result: got %b %h %0d want 1 7 4", fail, exit_code, cycle_count);
      end
   endtask

   task automatic test_random_runs();
      int lo, arm, wall, en, h, pa, pl;
      logic [31:0] v, want;
      for (int k = 0; k < 6; k++) begin
         v = ($urandom_range(0, 1) == 0) ? 32'h1 : ($urandom | 32'h2);
         h = $urandom_range(0, 200);
         pa = $urandom_range(0, h);
         pl = $urandom_range(0, 8);
         exp_q.push_back(v);
         drive_startup(1'b0, lo, arm);
         drive_body(h, v, pa, pl, wall, en);
         want = exp_q.pop_front();
         checks++; if (exit_code !== want) begin errors++; $display("FAIL rand_exit[%0d]: got %h want %h", k, exit_code, want); end
         checks++; if (run_state !== ((want == 32'h1) ? 3'd4 : 3'd5)) begin
            errors++; $display("FAIL rand_state[%0d]: got %0d want %0d", k, run_state, (want == 32'h1) ? 4 : 5);
         end
         checks++; if (cycle_count !== 32'(h + 1) || wall !== h + 1 + pl || en !== h + 1) begin
            errors++; $display("FAIL rand_count[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", k, cycle_count, wall, en, h + 1, h + 1 + pl, h + 1);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int lo, arm;
      drive_startup(1'b0, lo, arm);
      repeat (30) @(negedge clk);
      checks++; if (cycle_count !== 32'd30) begin errors++; $display("FAIL midrun_count: got %0d want 30", cycle_count); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({run_state, dut_rstn, dut_en, cycle_count} !== {3'd0, 2'b00, 32'd0}) begin
         errors++; $display("FAIL midrun_reset: got %0d %b %0d want 0 00 0", run_state, {dut_rstn, dut_en}, cycle_count);
      end
      rst = 1'b0;
   endtask

   task automatic test_en_delay0();
      int lo, n;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      lo = 0;
      for (int i = 0; i < 20 && !dut_rstn0; i++) begin
         lo++;
         @(negedge clk);
      end
      checks++; if (lo !== 3) begin errors++; $display("FAIL en0_rst_cycles: got %0d want 3", lo); end
      checks++; if ({dut_rstn0, dut_en0, run_state0} !== {2'b11, 3'd3}) begin
         errors++; $display("FAIL en0_rise: got %b %0d want 11 3", {dut_rstn0, dut_en0}, run_state0);
      end
      n = 0;
      while (run_state0 == 3'd3 && n < 200) begin
         n++;
         @(negedge clk);
      end
      checks++; if ({timeout0, cycle_count0, exit_code0} !== {1'b1, 32'(T0), 32'h0} || n !== T0) begin
         errors++; $display("FAIL en0_timeout: got %b %0d %h after %0d want 1 %0d 0 after %0d", timeout0, cycle_count0, exit_code0, n, T0, T0);
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_pass();
      test_fail_ignored();
      test_timeout_pause();
      test_hit_vs_timeout();
      test_rerun();
      test_random_runs();
      test_reset_mid_run();
      test_en_delay0();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
